// File: rtl/riscv_pkg.sv
// RV32I opcode/funct definitions, loader FSM states and the field-to-word encoder
// shared by the instruction loader and its reference model.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_FENCE  = 7'h0F,
    OP_I_TYPE = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_R_TYPE = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F,
    OP_SYSTEM = 7'h73
  } opcode_t;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } enc_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] word;
  } enc_result_t;

  function automatic enc_result_t encode_instr(
    input opcode_t     op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    enc_result_t r;
    r.valid = 1'b1;
    r.word  = '0;
    case (op)
      OP_R_TYPE: r.word = {funct7, rs2, rs1, funct3, rd, op};
      OP_I_TYPE: begin
        // shift-immediates take their upper bits from funct7, not imm
        if (funct3 == F3_SLL || funct3 == F3_SRL_SRA)
          r.word = {funct7, imm[4:0], rs1, funct3, rd, op};
        else
          r.word = {imm[11:0], rs1, funct3, rd, op};
      end
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:
        r.word = {imm[11:0], rs1, funct3, rd, op};
      OP_STORE: r.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      OP_BRANCH: begin
        r.word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        r.valid = ~imm[0];
      end
      OP_JAL: begin
        r.word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        r.valid = ~imm[0];
      end
      OP_LUI, OP_AUIPC: r.word = {imm[31:12], rd, op};
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational RV32I field-to-word encoder; valid=0 flags an unencodable beat.
module instr_encoder
  import riscv_pkg::*;
(
  input  opcode_t     opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        valid
);

  enc_result_t res;

  assign res   = encode_instr(opcode, rd, rs1, rs2, funct3, funct7, imm);
  assign word  = res.word;
  assign valid = res.valid;

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams decoded instruction fields in, encodes them and writes them to
// sequential instruction-memory words starting at BASE_ADDR.
//
// state    | meaning
// ST_IDLE  | no session since reset; waiting for start
// ST_RUN   | accepting beats, one write per accepted beat
// ST_FLUSH | last beat accepted; its write is on the bus this cycle
// ST_DONE  | session completed cleanly; done held until start
// ST_ERR   | session aborted (bad opcode, odd branch/jal target, overflow)
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  opcode_t             s_opcode,
  input  logic [4:0]          s_rd,
  input  logic [4:0]          s_rs1,
  input  logic [4:0]          s_rs2,
  input  logic [2:0]          s_funct3,
  input  logic [6:0]          s_funct7,
  input  logic [31:0]         s_imm,
  input  logic                s_last,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] word_count
);

  localparam logic [ADDR_WIDTH:0] MAX_WC = (ADDR_WIDTH + 1)'(MAX_WORDS);

  enc_state_t  state, state_next;
  logic [31:0] enc_word;
  logic        enc_valid;
  logic        hs;
  logic        accept;

  instr_encoder u_enc (
    .opcode (s_opcode),
    .rd     (s_rd),
    .rs1    (s_rs1),
    .rs2    (s_rs2),
    .funct3 (s_funct3),
    .funct7 (s_funct7),
    .imm    (s_imm),
    .word   (enc_word),
    .valid  (enc_valid)
  );

  assign s_ready = (state == ST_RUN);
  assign busy    = (state == ST_RUN) || (state == ST_FLUSH);
  assign done    = (state == ST_DONE);
  assign error   = (state == ST_ERR);

  // start in the same cycle as a handshake discards the beat
  assign hs     = s_valid && s_ready && !start;
  assign accept = hs && enc_valid && (word_count != MAX_WC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (hs && !accept)     state_next = ST_ERR;
          else if (hs && s_last) state_next = ST_FLUSH;
        end
        ST_FLUSH: state_next = ST_DONE;
        default:  state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      word_count <= '0;
    end else begin
      mem_we <= accept;
      if (start) begin
        word_count <= '0;
      end else if (accept) begin
        mem_addr   <= BASE_ADDR + (32'(word_count) << 2);
        mem_wdata  <= enc_word;
        word_count <= word_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: single-beat vector table plus
// hand-written multi-beat sequences (stream, overflow, stall, reset, restart).
module tb_instr_encoder_loader;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_last;
  opcode_t     s_opcode;
  logic [4:0]  s_rd, s_rs1, s_rs2;
  logic [2:0]  s_funct3;
  logic [6:0]  s_funct7;
  logic [31:0] s_imm;

  logic        s_ready, mem_we, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [10:0] word_count;

  logic        sm_ready, sm_we, sm_busy, sm_done, sm_error;
  logic [31:0] sm_addr, sm_wdata;
  logic [10:0] sm_count;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_opcode(s_opcode), .s_rd(s_rd), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s_funct3(s_funct3), .s_funct7(s_funct7), .s_imm(s_imm), .s_last(s_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  instr_encoder_loader #(.ADDR_WIDTH(10), .BASE_ADDR(32'h100), .MAX_WORDS(2)) dut_small (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(sm_ready),
    .s_opcode(s_opcode), .s_rd(s_rd), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s_funct3(s_funct3), .s_funct7(s_funct7), .s_imm(s_imm), .s_last(s_last),
    .mem_we(sm_we), .mem_addr(sm_addr), .mem_wdata(sm_wdata),
    .busy(sm_busy), .done(sm_done), .error(sm_error), .word_count(sm_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic set_beat(input opcode_t op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm, input logic last);
    s_valid = 1'b1; s_opcode = op; s_rd = rd; s_rs1 = rs1; s_rs2 = rs2;
    s_funct3 = f3; s_funct7 = f7; s_imm = imm; s_last = last;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    opcode_t     op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        err;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic rdy, v;
    int   sent, exp_idx;

    vecs[0] = '{"addi",  OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        1'b0, 32'h0050_0093};
    vecs[1] = '{"beq_m8", OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFF8, 1'b0, 32'hFE20_8CE3};
    vecs[2] = '{"jal16", OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd16,       1'b0, 32'h0100_00EF};
    vecs[3] = '{"lui",   OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5FFF, 1'b0, 32'h1234_52B7};
    vecs[4] = '{"srai",  OP_I_TYPE, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3,        1'b0, 32'h4030_D093};
    vecs[5] = '{"beq_6", OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd6,        1'b0, 32'h0020_8363};
    vecs[6] = '{"sw",    OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        1'b0, 32'h0020_A423};
    vecs[7] = '{"beq_5", OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd5,        1'b1, 32'h0};
    vecs[8] = '{"jal_3", OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,        1'b1, 32'h0};
    vecs[9] = '{"badop", opcode_t'(7'h7F), 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b1, 32'h0};

    rst = 1'b1; start = 1'b0; idle_in();
    set_beat(OP_I_TYPE, 0, 0, 0, 0, 0, 0, 0); s_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk1("rst_ready", s_ready, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_small_addr", sm_addr, 32'h100);

    // single-beat sessions from the vector table
    for (int i = 0; i < 10; i++) begin
      pulse_start();
      chk1({vecs[i].name, "_ready"}, s_ready, 1'b1);
      set_beat(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7,
               vecs[i].imm, 1'b1);
      tick();
      idle_in();
      if (vecs[i].err) begin
        chk1({vecs[i].name, "_we"}, mem_we, 1'b0);
        chk1({vecs[i].name, "_error"}, error, 1'b1);
        chk1({vecs[i].name, "_ready_low"}, s_ready, 1'b0);
        chk("vec_count", 32'(word_count), 32'd0);
      end else begin
        chk1({vecs[i].name, "_we"}, mem_we, 1'b1);
        chk({vecs[i].name, "_addr"}, mem_addr, 32'h0);
        chk({vecs[i].name, "_wdata"}, mem_wdata, vecs[i].word);
        chk1({vecs[i].name, "_busy"}, busy, 1'b1);
        tick();
        chk1({vecs[i].name, "_done"}, done, 1'b1);
        chk1({vecs[i].name, "_we_off"}, mem_we, 1'b0);
        chk("vec_count", 32'(word_count), 32'd1);
      end
    end

    // three-beat program
    pulse_start();
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 7'h00, 32'd5, 0); tick();
    chk1("prog_we0", mem_we, 1'b1); chk("prog_addr0", mem_addr, 32'h0);
    chk("prog_wdata0", mem_wdata, 32'h0050_0093);
    set_beat(OP_R_TYPE, 3, 1, 2, 0, 7'h20, 32'd0, 0); tick();
    chk("prog_addr1", mem_addr, 32'h4); chk("prog_wdata1", mem_wdata, 32'h4020_81B3);
    set_beat(OP_STORE, 0, 1, 2, 3'd2, 7'h00, 32'd8, 1); tick();
    idle_in();
    chk1("prog_we2", mem_we, 1'b1); chk("prog_addr2", mem_addr, 32'h8);
    chk("prog_wdata2", mem_wdata, 32'h0020_A423);
    chk1("prog_flush_ready", s_ready, 1'b0);
    tick();
    chk1("prog_done", done, 1'b1); chk1("prog_busy", busy, 1'b0);
    chk("prog_count", 32'(word_count), 32'd3); chk1("prog_we_off", mem_we, 1'b0);
    tick(); tick();
    chk1("prog_done_held", done, 1'b1);

    // overflow on the MAX_WORDS=2 instance
    pulse_start();
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd1, 0); tick();
    chk1("ovf_we0", sm_we, 1'b1); chk("ovf_addr0", sm_addr, 32'h100);
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd2, 0); tick();
    chk1("ovf_we1", sm_we, 1'b1); chk("ovf_addr1", sm_addr, 32'h104);
    chk("ovf_wdata1", sm_wdata, 32'h0020_0093);
    chk1("ovf_ready_still", sm_ready, 1'b1);
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd3, 0); tick();
    idle_in();
    chk1("ovf_we2", sm_we, 1'b0); chk1("ovf_error", sm_error, 1'b1);
    chk1("ovf_ready", sm_ready, 1'b0); chk("ovf_count", 32'(sm_count), 32'd2);
    tick();
    chk1("ovf_we_after", sm_we, 1'b0); chk1("ovf_error_held", sm_error, 1'b1);

    // random stalls over 10 beats
    pulse_start();
    sent = 0; exp_idx = 0;
    for (int c = 0; c < 200 && exp_idx < 10; c++) begin
      if (sent < 10 && $urandom_range(0, 1) == 1)
        set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'(sent), sent == 9);
      else
        idle_in();
      rdy = s_ready; v = s_valid;
      tick();
      if (v && rdy) sent++;
      if (mem_we) begin
        chk("stall_addr", mem_addr, 32'(exp_idx) << 2);
        chk("stall_wdata", mem_wdata, (32'(exp_idx) << 20) | 32'h93);
        exp_idx++;
      end
    end
    idle_in();
    chk("stall_writes", 32'(exp_idx), 32'd10);
    chk("stall_count", 32'(word_count), 32'd10);
    tick();
    chk1("stall_done", done, 1'b1);

    // reset between beats 2 and 3
    pulse_start();
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd1, 0); tick();
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd2, 0); tick();
    chk1("mid_we", mem_we, 1'b1); chk("mid_addr", mem_addr, 32'h4);
    rst = 1'b1; idle_in();
    #1;
    chk1("arst_we", mem_we, 1'b0); chk("arst_addr", mem_addr, 32'h0);
    chk("arst_wdata", mem_wdata, 32'h0); chk1("arst_busy", busy, 1'b0);
    chk1("arst_ready", s_ready, 1'b0); chk("arst_count", 32'(word_count), 32'd0);
    chk1("arst_done", done, 1'b0); chk1("arst_error", error, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk1("post_rst_idle_ready", s_ready, 1'b0);
    pulse_start();
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd4, 1); tick();
    idle_in();
    chk1("post_rst_we", mem_we, 1'b1); chk("post_rst_addr", mem_addr, 32'h0);
    chk("post_rst_count", 32'(word_count), 32'd1);

    // start colliding with a handshake wins and drops the beat
    tick();
    pulse_start();
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd7, 0); tick();
    chk1("rs_we0", mem_we, 1'b1); chk("rs_wdata0", mem_wdata, 32'h0070_0093);
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd9, 0); start = 1'b1; tick();
    start = 1'b0;
    chk1("rs_we_drop", mem_we, 1'b0); chk("rs_count", 32'(word_count), 32'd0);
    chk1("rs_ready", s_ready, 1'b1);
    set_beat(OP_I_TYPE, 1, 0, 0, 0, 0, 32'd11, 1); tick();
    idle_in();
    chk1("rs_we1", mem_we, 1'b1); chk("rs_addr1", mem_addr, 32'h0);
    chk("rs_wdata1", mem_wdata, 32'h00B0_0093); chk("rs_count1", 32'(word_count), 32'd1);
    tick();
    chk1("rs_done", done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Encoder-side counterpart to the core's instruction decode path. It accepts decoded instruction fields (opcode, register indices, funct3/funct7, full-width immediate) over a valid/ready stream, assembles each into a 32-bit RV32I word per its format, and writes the words sequentially into instruction memory. It sits between a host/debug command source and the instruction memory write port, and is used for boot loading and self-test program generation.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-index width; capacity is 2^ADDR_WIDTH words
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- MAX_WORDS, 1024, words accepted per session before overflow; must be ≤ 2^ADDR_WIDTH

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new session: clears index and flags
- s_valid  in  1  field beat valid
- s_ready  out  1  beat accepted when s_valid && s_ready
- s_opcode  in  opcode_t (7)  instruction opcode
- s_rd, s_rs1, s_rs2  in  5 each  register indices
- s_funct3  in  3  funct3
- s_funct7  in  7  funct7; also supplies bits [31:25] for I-type shifts
- s_imm  in  32  immediate, sign-extended value; for U-type, the final value with bits [11:0] ignored
- s_last  in  1  final beat of the session
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  32  byte address
- mem_wdata  out  32  encoded instruction
- busy  out  1  session in progress
- done  out  1  session completed cleanly; held until start
- error  out  1  session aborted; held until start
- word_count  out  ADDR_WIDTH+1  words written this session

## Operation
FSM states: IDLE, RUN, FLUSH, DONE, ERR.
- IDLE: s_ready=0. start → RUN, index=0, word_count=0.
- RUN: s_ready=1. Each handshake registers the encoded word, asserts mem_we on the next cycle at BASE_ADDR + 4·index, then increments index and word_count. Throughput is 1 word/cycle.
- A handshake with s_last → FLUSH. FLUSH completes the final write, then → DONE with done=1.
- DONE and ERR: s_ready=0. start → RUN with a fresh session.
- start while in RUN or FLUSH restarts the session: any pending write is dropped and counters are cleared.

Encoding (bit order MSB→LSB):
- OP_R_TYPE: funct7, rs2, rs1, funct3, rd, op
- OP_I_TYPE with funct3 F3_SLL/F3_SRL_SRA: funct7, imm[4:0], rs1, funct3, rd, op
- Other OP_I_TYPE, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: imm[11:0], rs1, funct3, rd, op
- OP_STORE: imm[11:5], rs2, rs1, funct3, imm[4:0], op
- OP_BRANCH: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op
- OP_JAL: imm[20], imm[10:1], imm[11], imm[19:12], rd, op
- OP_LUI, OP_AUIPC: imm[31:12], rd, op

Errors (→ ERR, error=1, no write for the offending beat; earlier writes stand):
- Opcode not in opcode_t.
- OP_BRANCH/OP_JAL with imm[0]=1.
- Handshake when word_count == MAX_WORDS (overflow).

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, word_count=0; state IDLE.
- Latency: handshake at cycle N → mem_we/addr/wdata valid in cycle N+1. word_count is updated in N+1.
- busy=1 in RUN and FLUSH only.
- s_ready is registered from state and does not depend on s_valid.
- The error check happens at handshake. s_ready drops the cycle after the offending beat; a prior beat's write still issues.
- Reset mid-session aborts immediately: the in-flight write is lost and mem_we is 0 from reset assertion.
- start and s_valid in the same cycle as a RUN handshake: start wins and the beat is not written.

## Structure
- riscv_pkg gains:
  - typedef enc_state_t for the FSM states.
  - function encode_instr(opcode, rd, rs1, rs2, funct3, funct7, imm) returning a 32-bit word plus a valid bit. The verification reference model reuses this function.
- Natural sub-module: instr_encoder, a combinational field-to-word encoder. The top holds the FSM, counters and output registers.

## Test plan
- BASE_ADDR=0. Stream addi x1,x0,5 (op 0x13, rd1, imm 5); sub x3,x1,x2 (f7 0x20); sw x2,8(x1) with s_last → mem writes 0x00500093 @0, 0x402081B3 @4, 0x0020A423 @8; done=1; word_count=3.
- beq x1,x2,-8 → 0xFE208CE3. jal x1,16 → 0x010000EF. lui x5 with imm 0x12345000 → 0x123452B7. srai x1,x1,3 (f7 0x20) → 0x4030D093.
- MAX_WORDS=2, three beats back-to-back with no s_last → two writes, then error=1 and s_ready=0; a third write never occurs.
- Branch with imm=6 (imm[0]=0) is encoded; branch with imm=5 → error, no write.
- Stall s_valid randomly for 10 beats → addresses contiguous, no gaps or duplicates.
- Assert rst between beats 2 and 3 → all outputs at reset values. A following start begins again at BASE_ADDR with word_count=0.
